// File: rtl/mem_stage_if.sv
// Data bus between the memory stage and the data memory / bus fabric.
//
// Signals
//   bus_req    master -> slave  request valid, held until bus_gnt
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  word address, bits [1:0] always zero
//   bus_wdata  master -> slave  store data already placed on its byte lanes
//   bus_be     master -> slave  byte enables
//   bus_gnt    slave -> master  request accepted this cycle
//   bus_rvalid slave -> master  bus_rdata carries read data this cycle
//   bus_rdata  slave -> master  raw 32-bit read word
interface mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: turns a load/store from the execute stage into a
// single data-bus transaction, extracts/extends load data and stalls the
// pipeline while the access is in flight.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   ex_valid       execute stage presents an instruction
//   ex_mem_read    instruction is a load
//   ex_mem_write   instruction is a store
//   ex_funct3      access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   ex_addr        byte address
//   ex_wdata       store data, LSB-aligned
//   bus            data bus (mem_stage_if master side)
//   mem_rdata      extended load data for writeback, held between loads
//   mem_done       one-cycle pulse when an access completes
//   mem_fault      one-cycle pulse when an access is aborted
//   stall          hold the execute stage
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  mem_stage_if.master       bus,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_fault,
  output logic              stall
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} state_t;

  state_t      state_reg, state_next;
  logic        done_next;
  logic        capture;
  logic [CW-1:0] cnt_reg;
  logic [2:0]  f3_reg;
  logic [1:0]  lo_reg;

  logic        access;
  logic        f3_ok;
  logic        aligned;
  logic        access_ok;
  logic        timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Any memory instruction counts as an access; only legal ones reach the bus.
  assign access = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    f3_ok = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ex_mem_read;  // unsigned forms are load-only
      default:                f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    case (ex_funct3[1:0])
      2'b01:   aligned = ~ex_addr[0];
      2'b10:   aligned = (ex_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign access_ok   = (ex_mem_read ^ ex_mem_write) & f3_ok & aligned;
  assign timeout_hit = (cnt_reg >= CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_calc = 4'b1111;
    case (ex_funct3[1:0])
      2'b00:   be_calc = 4'b0001 << ex_addr[1:0];
      2'b01:   be_calc = 4'b0011 << ex_addr[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  // Replicate the store data so every enabled lane carries the right byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_calc[8*gi +: 8] =
      (ex_funct3[1:0] == 2'b00) ? ex_wdata[7:0] :
      (ex_funct3[1:0] == 2'b01) ? ex_wdata[8*(gi%2) +: 8] :
                                  ex_wdata[8*gi +: 8];
  end

  assign rd_byte = bus.bus_rdata[{lo_reg, 3'b000} +: 8];
  assign rd_half = bus.bus_rdata[{lo_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = bus.bus_rdata;
    case (f3_reg)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        // In the done cycle the pipeline is still moving the finished
        // instruction out, so it must not be captured a second time.
        if (access && !mem_done) begin
          if (access_ok) begin
            state_next = REQ;
            capture    = 1'b1;
          end else begin
            state_next = FAULT;
          end
        end
      end
      REQ: begin
        if (bus.bus_gnt) begin
          if (bus.bus_we) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end else if (timeout_hit) begin
          state_next = FAULT;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (timeout_hit) begin
          state_next = FAULT;
        end
      end
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.bus_req = (state_reg == REQ);
  assign mem_fault   = (state_reg == FAULT);
  assign stall       = ~rst & ~mem_done & ~mem_fault & ((state_reg != IDLE) | access);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
      bus.bus_be    <= 4'd0;
      mem_rdata     <= 32'd0;
      mem_done      <= 1'b0;
      cnt_reg       <= '0;
      f3_reg        <= 3'd0;
      lo_reg        <= 2'd0;
    end else begin
      mem_done <= done_next;
      if (capture) begin
        cnt_reg       <= '0;
        bus.bus_we    <= ex_mem_write;
        bus.bus_addr  <= {ex_addr[31:2], 2'b00};
        bus.bus_wdata <= wdata_calc;
        bus.bus_be    <= be_calc;
        f3_reg        <= ex_funct3;
        lo_reg        <= ex_addr[1:0];
      end else if (state_reg == REQ || state_reg == WAIT) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (state_reg == WAIT && bus.bus_rvalid) begin
        mem_rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_fault;
  logic        stall;

  mem_stage_if bus_if ();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .bus          (bus_if),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .mem_fault    (mem_fault),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rdata = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    bit ok;
    if (rd == wr) return 1'b0;
    if (rd) ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else    ok = f3 inside {3'd0, 3'd1, 3'd2};
    if (!ok) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << size_of(f3)) - 1) << a[1:0];
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = size_of(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] raw);
    logic [31:0] v, mask;
    int sz;
    sz = size_of(f3);
    if (sz == 4) return raw;
    mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (raw >> (8 * int'(a[1:0]))) & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    ex_valid     = 1'b1;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_funct3    = f3;
    ex_addr      = a;
    ex_wdata     = wd;
  endtask

  task automatic req_fields(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
    check("req_active", bus_if.bus_req, 1);
    check("req_addr", bus_if.bus_addr, {a[31:2], 2'b00});
    check("req_we", bus_if.bus_we, wr);
    check("req_be", bus_if.bus_be, exp_be(f3, a));
    if (wr) check("req_wdata", bus_if.bus_wdata, exp_wdata(f3, wd));
    check("req_stall", stall, 1);
    check("req_no_done", mem_done, 0);
  endtask

  // Runs one access from its capture cycle; returns in the done/fault cycle
  // with the instruction still presented.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] raw);
    bit legal;
    legal = is_legal(rd, wr, f3, a);
    drive(rd, wr, f3, a, wd);
    #1;
    check("capture_stall", stall, 1);
    check("capture_no_req", bus_if.bus_req, 0);
    if (!legal) begin
      step();
      check("fault_pulse", mem_fault, 1);
      check("fault_no_done", mem_done, 0);
      check("fault_no_req", bus_if.bus_req, 0);
      check("fault_stall", stall, 0);
      check("fault_rdata_kept", mem_rdata, model_rdata);
      $display("access rd=%0d wr=%0d f3=%0d addr=%h -> fault", rd, wr, f3, a);
      return;
    end
    step();
    for (int i = 0; i < gnt_dly; i++) begin
      req_fields(wr, f3, a, wd);
      step();
    end
    bus_if.bus_gnt = 1'b1;
    if (rd) begin
      bus_if.bus_rvalid = 1'b1;  // must be ignored alongside gnt
      bus_if.bus_rdata  = ~raw;
    end
    #1;
    req_fields(wr, f3, a, wd);
    step();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    if (rd) begin
      for (int i = 0; i < rv_dly; i++) begin
        check("wait_no_req", bus_if.bus_req, 0);
        check("wait_no_done", mem_done, 0);
        check("wait_stall", stall, 1);
        step();
      end
      check("wait_no_req", bus_if.bus_req, 0);
      check("wait_no_early_done", mem_done, 0);
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = raw;
      step();
      bus_if.bus_rvalid = 1'b0;
      model_rdata = exp_load(f3, a, raw);
    end
    check("done_pulse", mem_done, 1);
    check("done_no_fault", mem_fault, 0);
    check("done_stall", stall, 0);
    check("done_no_req", bus_if.bus_req, 0);
    check("done_rdata", mem_rdata, model_rdata);
    $display("access rd=%0d wr=%0d f3=%0d addr=%h gnt_dly=%0d rv_dly=%0d -> done rdata=%h",
             rd, wr, f3, a, gnt_dly, rv_dly, mem_rdata);
  endtask

  task automatic go_idle();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    step();
    check("idle_no_done", mem_done, 0);
    check("idle_no_fault", mem_fault, 0);
    check("idle_no_req", bus_if.bus_req, 0);
    check("idle_stall", stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'd0;

    // Reset state
    repeat (3) step();
    check("rst_req", bus_if.bus_req, 0);
    check("rst_addr", bus_if.bus_addr, 0);
    check("rst_be", bus_if.bus_be, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;
    step();
    check("post_rst_done", mem_done, 0);
    check("post_rst_fault", mem_fault, 0);

    // LB 0x1003, gnt after 2 cycles, rvalid the cycle after gnt
    run_access(1, 0, 3'b000, 32'h0000_1003, 32'd0, 2, 0, 32'h80FF_FF00);
    check("lb_sext", mem_rdata, 32'hFFFF_FF80);
    go_idle();

    // SH 0x2002 with immediate grant
    run_access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 0, 32'd0);
    check("sh_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
    check("sh_be", bus_if.bus_be, 4'b1100);
    check("sh_rdata_kept", mem_rdata, 32'hFFFF_FF80);
    go_idle();

    // Misaligned LW
    run_access(1, 0, 3'b010, 32'h0000_0006, 32'd0, 0, 0, 32'd0);
    go_idle();

    // LHU timeout: grant in the first request cycle, then no rvalid
    drive(1, 0, 3'b101, 32'h0000_0002, 32'd0);
    #1;
    step();
    for (int c = 1; c <= TO; c++) begin
      bus_if.bus_gnt = (c == 1);
      #1;
      check("to_no_fault", mem_fault, 0);
      check("to_req", bus_if.bus_req, (c == 1) ? 32'd1 : 32'd0);
      step();
    end
    bus_if.bus_gnt = 1'b0;
    check("to_fault", mem_fault, 1);
    check("to_fault_no_req", bus_if.bus_req, 0);
    check("to_fault_no_done", mem_done, 0);
    $display("access LHU addr=00000002 timeout -> fault");
    ex_valid = 1'b0;
    ex_mem_read = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h1234_5678;
    step();
    bus_if.bus_rvalid = 1'b0;
    check("to_late_rvalid_done", mem_done, 0);
    check("to_late_rvalid_rdata", mem_rdata, model_rdata);
    step();
    check("to_late_rvalid_done2", mem_done, 0);

    // Reset while waiting for read data
    drive(1, 0, 3'b010, 32'h0000_0040, 32'd0);
    #1;
    step();
    bus_if.bus_gnt = 1'b1;
    step();
    bus_if.bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_wait_req", bus_if.bus_req, 0);
    check("rst_wait_addr", bus_if.bus_addr, 0);
    check("rst_wait_be", bus_if.bus_be, 0);
    check("rst_wait_rdata", mem_rdata, 0);
    check("rst_wait_stall", stall, 0);
    check("rst_wait_fault", mem_fault, 0);
    model_rdata = 32'd0;
    step();
    rst = 1'b0;
    ex_valid = 1'b0;
    ex_mem_read = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hDEAD_BEEF;
    step();
    bus_if.bus_rvalid = 1'b0;
    check("rst_rvalid_no_done", mem_done, 0);
    check("rst_rvalid_rdata", mem_rdata, 0);
    step();
    check("rst_rvalid_no_done2", mem_done, 0);
    $display("reset during WAIT -> access abandoned");

    // Back-to-back SW then LBU with ex_valid held high
    run_access(0, 1, 3'b010, 32'h0000_0100, 32'h0BAD_F00D, 0, 0, 32'd0);
    drive(1, 0, 3'b100, 32'h0000_0105, 32'd0);
    #1;
    check("b2b_done_cycle_no_req", bus_if.bus_req, 0);
    check("b2b_done_cycle_stall", stall, 0);
    step();
    check("b2b_no_dup_req", bus_if.bus_req, 0);
    run_access(1, 0, 3'b100, 32'h0000_0105, 32'd0, 1, 1, 32'h1122_E344);
    go_idle();

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      int op, gd, rvd, sz;
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a, wd, raw;
      op  = $urandom_range(0, 11);
      a   = $urandom;
      wd  = $urandom;
      raw = $urandom;
      if (op == 0) begin
        drive(0, 0, 3'($urandom_range(0, 7)), a, wd);
        #1;
        check("nop_stall", stall, 0);
        step();
        check("nop_no_req", bus_if.bus_req, 0);
        check("nop_no_done", mem_done, 0);
        check("nop_no_fault", mem_fault, 0);
        $display("access rd=0 wr=0 addr=%h -> no effect", a);
        go_idle();
      end else begin
        rd = (op == 1) ? 1'b1 : op[0];
        wr = (op == 1) ? 1'b1 : ~op[0];
        if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
        else if (rd) f3 = 3'($urandom_range(0, 4) == 4 ? 5 : $urandom_range(0, 4));
        else f3 = 3'($urandom_range(0, 2));
        sz = size_of(f3);
        if ($urandom_range(0, 4) != 0) a = a & ~(32'(sz) - 32'd1);
        gd  = $urandom_range(0, 2);
        rvd = $urandom_range(0, 2 - gd);
        run_access(rd, wr, f3, a, wd, gd, rvd, raw);
        go_idle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
